ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_pkg.sv | 50 +++++
 rtl/ahb_rr_picker.sv | 28 ++
 rtl/ahb_arbiter.sv | 135 +++++++++++++
 tb/tb_ahb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state enumeration and burst-length decode
// used by the bus arbiter and its round-robin picker.
package ahb_pkg;

  localparam int unsigned MIDX_W = 4;
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE_DEFAULT   = 2'b00,
    ST_OWNED          = 2'b01,
    ST_LOCKED         = 2'b10,
    ST_SPLIT_HANDOVER = 2'b11
  } arb_state_e;

  // Beats remaining after the first beat; zero for SINGLE and undefined-length INCR.
  function automatic logic [BEAT_W-1:0] burst_len_m1(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      HBURST_WRAP4,  HBURST_INCR4:  return BEAT_W'(3);
      HBURST_WRAP8,  HBURST_INCR8:  return BEAT_W'(7);
      HBURST_WRAP16, HBURST_INCR16: return BEAT_W'(15);
      default:                      return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin request picker: first unmasked requester after the last owner,
// wrapping around, with the last owner itself considered last.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      mask,
  input  logic [MIDX_W-1:0] last,
  output logic [N-1:0]      grant,
  output logic              valid
);

  always_comb begin : pick_c
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && ((32'(last) + i) % N == j) && req[j] && !mask[j]) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst-aware arbitration points,
// locked-transfer hold and SPLIT masking/release.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [15:0]            hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MIDX_W-1:0]      hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DFLT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e               state, state_nxt;
  logic [BEAT_W-1:0]        beat_cnt, cnt_nxt;
  logic [NUM_MASTERS-1:0]   split_mask, mask_nxt, set_vec;
  logic [NUM_MASTERS-1:0]   pick_grant, park_grant, gnt_nxt;
  logic [MIDX_W-1:0]        gidx, hmaster_nxt;
  logic                     pick_valid, park_found, split_evt, arb_point;
  logic                     fixed_burst, keep, owned_nxt, hmastlock_nxt;
  logic                     unused_hsplit;

  assign unused_hsplit = ^hsplit;
  assign split_evt     = (hresp == HRESP_SPLIT) && !hready;

  // Split release has priority over a split set landing in the same cycle.
  always_comb begin : mask_c
    set_vec = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      set_vec[i] = split_evt && (hmaster == MIDX_W'(i));
    mask_nxt = (split_mask | set_vec) & ~hsplit[NUM_MASTERS-1:0];
  end

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req   (hbusreq),
    .mask  (mask_nxt),
    .last  (hmaster),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Parking target: default master unless masked, then lowest unmasked master.
  always_comb begin : park_c
    park_grant = DFLT_GRANT;
    park_found = 1'b0;
    if ((DFLT_GRANT & mask_nxt) != '0) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!park_found && !mask_nxt[i]) begin
          park_grant    = '0;
          park_grant[i] = 1'b1;
          park_found    = 1'b1;
        end
      end
    end
  end

  always_comb begin : gidx_c
    gidx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++)
      if (hgrant[i]) gidx = MIDX_W'(i);
  end

  always_comb begin : next_c
    gnt_nxt       = hgrant;
    cnt_nxt       = beat_cnt;
    hmaster_nxt   = hmaster;
    hmastlock_nxt = hmastlock;
    state_nxt     = state;

    fixed_burst = (burst_len_m1(hburst) != '0);
    arb_point   = hready && ((htrans == HTRANS_IDLE) || !fixed_burst ||
                             ((htrans == HTRANS_SEQ) && (beat_cnt <= BEAT_W'(1))));
    keep        = |(hgrant & hlock & ~mask_nxt);

    if (split_evt || (arb_point && !keep))
      gnt_nxt = pick_valid ? pick_grant : park_grant;

    if (hready) begin
      if (htrans == HTRANS_NONSEQ)
        cnt_nxt = burst_len_m1(hburst);
      else if ((htrans == HTRANS_SEQ) && (beat_cnt != '0))
        cnt_nxt = beat_cnt - BEAT_W'(1);
      hmaster_nxt   = gidx;
      hmastlock_nxt = keep;
    end

    owned_nxt = |(gnt_nxt & hbusreq & ~mask_nxt);

    if (split_evt) begin
      state_nxt = ST_SPLIT_HANDOVER;
    end else begin
      case (state)
        ST_IDLE_DEFAULT:   if (owned_nxt) state_nxt = ST_OWNED;
        ST_OWNED: begin
          if (hready && keep) state_nxt = ST_LOCKED;
          else if (!owned_nxt) state_nxt = ST_IDLE_DEFAULT;
        end
        ST_LOCKED:         if (hready && !keep)
                             state_nxt = owned_nxt ? ST_OWNED : ST_IDLE_DEFAULT;
        ST_SPLIT_HANDOVER: state_nxt = owned_nxt ? ST_OWNED : ST_IDLE_DEFAULT;
        default:           state_nxt = ST_IDLE_DEFAULT;
      endcase
    end
  end

  always_ff @(posedge hclk) begin : regs_p
    if (hreset) begin
      hgrant     <= DFLT_GRANT;
      hmaster    <= MIDX_W'(DEFAULT_MASTER);
      hmastlock  <= 1'b0;
      split_mask <= '0;
      beat_cnt   <= '0;
      state      <= ST_IDLE_DEFAULT;
    end else begin
      hgrant     <= gnt_nxt;
      hmaster    <= hmaster_nxt;
      hmastlock  <= hmastlock_nxt;
      split_mask <= mask_nxt;
      beat_cnt   <= cnt_nxt;
      state      <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus randomized traffic checked
// against a beat-counting reference model for a 4-master and a 2-master arbiter.
module tb_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [3:0]  hbusreq, hlock;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hburst;
  logic        hready;
  logic [15:0] hsplit;
  logic [3:0]  hgrant4, hmaster4, hmaster2;
  logic [1:0]  hgrant2;
  logic        hmastlock4, hmastlock2;

  int checks = 0;
  int errors = 0;

  // Model state per arbiter: [0] = 4 masters, [1] = 2 masters; default master 0.
  int         m_g[2], m_hm[2], m_done[2], m_len[2];
  logic       m_lk[2];
  logic [3:0] m_mask[2];

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) u_dut4 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hsplit(hsplit), .hgrant(hgrant4), .hmaster(hmaster4), .hmastlock(hmastlock4)
  );

  ahb_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq[1:0]), .hlock(hlock[1:0]),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hsplit(hsplit), .hgrant(hgrant2), .hmaster(hmaster2), .hmastlock(hmastlock2)
  );

  // One clock edge; the model predicts from the inputs present at the edge.
  task automatic tick();
    int ng[2], nhm[2], ndone[2], nlen[2];
    logic nlk[2];
    logic [3:0] nmask[2];
    for (int u = 0; u < 2; u++) begin
      int n, len, pick, park;
      logic split, fixed, last, arb, keep;
      n = (u == 0) ? 4 : 2;
      if (hreset) begin
        ng[u] = 0; nhm[u] = 0; nlk[u] = 1'b0; nmask[u] = '0; ndone[u] = 0; nlen[u] = 0;
      end else begin
        split = (hresp == 2'b11) && !hready;
        nmask[u] = '0;
        for (int m = 0; m < n; m++)
          nmask[u][m] = (m_mask[u][m] || (split && m == m_hm[u])) && !hsplit[m];
        fixed = (hburst >= 3'd2);
        len = (hburst[2:1] == 2'd1) ? 4 : (hburst[2:1] == 2'd2) ? 8 : (hburst[2:1] == 2'd3) ? 16 : 1;
        last = fixed && (htrans == 2'b11) && (m_done[u] + 1 >= m_len[u]);
        arb = hready && (htrans == 2'b00 || !fixed || last);
        ndone[u] = m_done[u];
        nlen[u]  = m_len[u];
        if (hready && htrans == 2'b10) begin
          ndone[u] = 1; nlen[u] = len;
        end else if (hready && htrans == 2'b11 && m_done[u] < 32) begin
          ndone[u] = m_done[u] + 1;
        end
        pick = -1;
        for (int k = 1; k <= n; k++) begin
          int c;
          c = (m_hm[u] + k) % n;
          if (pick < 0 && hbusreq[c] && !nmask[u][c]) pick = c;
        end
        park = 0;
        if (nmask[u][0])
          for (int m = n - 1; m >= 0; m--) if (!nmask[u][m]) park = m;
        keep = hlock[m_g[u]] && !nmask[u][m_g[u]];
        ng[u] = m_g[u];
        if (split || (arb && !keep)) ng[u] = (pick >= 0) ? pick : park;
        nhm[u] = m_hm[u];
        nlk[u] = m_lk[u];
        if (hready) begin
          nhm[u] = m_g[u];
          nlk[u] = keep;
        end
      end
    end
    @(posedge hclk);
    #1;
    for (int u = 0; u < 2; u++) begin
      m_g[u] = ng[u]; m_hm[u] = nhm[u]; m_lk[u] = nlk[u];
      m_mask[u] = nmask[u]; m_done[u] = ndone[u]; m_len[u] = nlen[u];
    end
  endtask

  task automatic idle_inputs();
    hbusreq = '0; hlock = '0; htrans = 2'b00; hburst = 3'b000;
    hready = 1'b1; hresp = 2'b00; hsplit = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  // Single requester m: granted on the first edge, owns the address phase on the second.
  task automatic grant_to(input int m);
    hbusreq = 4'(1 << m);
    htrans  = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hgrant4 !== 4'b0001) begin errors++; $display("FAIL reset_hgrant got %b want 0001", hgrant4); end
    checks++; if (hmaster4 !== 4'd0) begin errors++; $display("FAIL reset_hmaster got %0d want 0", hmaster4); end
    checks++; if (hmastlock4 !== 1'b0) begin errors++; $display("FAIL reset_hmastlock got %b want 0", hmastlock4); end
    checks++; if (hgrant2 !== 2'b01) begin errors++; $display("FAIL reset_hgrant2 got %b want 01", hgrant2); end
  endtask

  task automatic test_round_robin();
    int owners[$];
    int prev, cur;
    do_reset();
    hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'b000;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cur = -1;
      for (int j = 0; j < 4; j++) if (hgrant4[j]) cur = j;
      checks++;
      if (hgrant4 !== 4'b0010 && hgrant4 !== 4'b0100) begin
        errors++; $display("FAIL rr_grant_set got %b want 0010 or 0100", hgrant4);
      end
      if (cur != prev) owners.push_back(cur);
      prev = cur;
    end
    checks++;
    if (owners.size() < 4 || owners[0] != 1 || owners[1] != 2 || owners[2] != 1 || owners[3] != 2) begin
      errors++; $display("FAIL rr_order got %p want 1,2,1,2", owners);
    end
  endtask

  task automatic test_incr4();
    logic [1:0] tr [5];
    logic [3:0] eg [5];
    tr = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
    eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    do_reset();
    grant_to(1);
    hbusreq = 4'b1010; hburst = 3'b011;
    for (int k = 0; k < 5; k++) begin
      htrans = tr[k];
      tick();
      checks++;
      if (hgrant4 !== eg[k]) begin errors++; $display("FAIL incr4_step%0d got %b want %b", k, hgrant4, eg[k]); end
    end
  endtask

  task automatic test_locked();
    do_reset();
    hlock = 4'b0100;
    grant_to(2);
    hbusreq = 4'b0101; htrans = 2'b10; hburst = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (hgrant4 !== 4'b0100) begin errors++; $display("FAIL lock_hgrant%0d got %b want 0100", k, hgrant4); end
      checks++; if (hmastlock4 !== 1'b1) begin errors++; $display("FAIL lock_hmastlock%0d got %b want 1", k, hmastlock4); end
    end
    hlock = 4'b0000;
    tick();
    checks++; if (hgrant4 !== 4'b0001) begin errors++; $display("FAIL unlock_hgrant got %b want 0001", hgrant4); end
    checks++; if (hmastlock4 !== 1'b0) begin errors++; $display("FAIL unlock_hmastlock got %b want 0", hmastlock4); end
  endtask

  task automatic test_split();
    int waited;
    do_reset();
    grant_to(1);
    hbusreq = 4'b1010; htrans = 2'b10; hburst = 3'b111;
    tick();
    htrans = 2'b11; hready = 1'b0; hresp = 2'b11;
    tick();
    checks++; if (hgrant4 !== 4'b1000) begin errors++; $display("FAIL split_handover got %b want 1000", hgrant4); end
    hready = 1'b1; hresp = 2'b00; htrans = 2'b00; hbusreq = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (hgrant4[1] !== 1'b0) begin errors++; $display("FAIL split_masked%0d got %b want bit1=0", k, hgrant4); end
    end
    hsplit = 16'h0002;
    tick();
    hsplit = '0;
    waited = 0;
    while (hgrant4 !== 4'b0010 && waited < 3) begin
      tick();
      waited++;
    end
    checks++; if (hgrant4 !== 4'b0010) begin errors++; $display("FAIL split_regrant got %b want 0010", hgrant4); end
  endtask

  task automatic test_reset_mid_split();
    do_reset();
    grant_to(1);
    hbusreq = 4'b1010; htrans = 2'b10; hburst = 3'b111;
    tick();
    htrans = 2'b11; hready = 1'b0; hresp = 2'b11;
    tick();
    hreset = 1'b1;
    tick();
    checks++; if (hgrant4 !== 4'b0001 || hmaster4 !== 4'd0) begin
      errors++; $display("FAIL midsplit_reset got %b/%0d want 0001/0", hgrant4, hmaster4);
    end
    hreset = 1'b0; hready = 1'b1; hresp = 2'b00; htrans = 2'b00; hbusreq = 4'b0010;
    tick();
    checks++; if (hgrant4 !== 4'b0010) begin errors++; $display("FAIL midsplit_unmasked got %b want 0010", hgrant4); end
  endtask

  task automatic test_all_masked();
    do_reset();
    grant_to(1);
    hbusreq = 4'b0011; htrans = 2'b10; hburst = 3'b111;
    tick();
    htrans = 2'b11; hready = 1'b0; hresp = 2'b11;
    tick();
    checks++; if (hgrant2 !== 2'b01) begin errors++; $display("FAIL allmask_first got %b want 01", hgrant2); end
    htrans = 2'b10; hready = 1'b1; hresp = 2'b00;
    tick();
    htrans = 2'b11; hready = 1'b0; hresp = 2'b11;
    tick();
    checks++; if (hgrant2 !== 2'b01) begin errors++; $display("FAIL allmask_grant got %b want 01", hgrant2); end
    htrans = 2'b00; hready = 1'b1; hresp = 2'b00; hlock = 4'b0011;
    tick();
    checks++; if (hgrant2 !== 2'b01) begin errors++; $display("FAIL allmask_park got %b want 01", hgrant2); end
    checks++; if (hmastlock2 !== 1'b0) begin errors++; $display("FAIL allmask_lock got %b want 0", hmastlock2); end
    hsplit = 16'h0002;
    tick();
    hsplit = '0; hlock = '0;
    checks++; if (hgrant2 !== 2'b10) begin errors++; $display("FAIL allmask_release got %b want 10", hgrant2); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      hreset  = ($urandom_range(0, 63) == 0);
      hbusreq = 4'($urandom);
      hlock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      htrans  = 2'($urandom);
      hburst  = 3'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      r       = $urandom_range(0, 7);
      hresp   = (r == 0) ? 2'b11 : (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b00;
      hsplit  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0000;
      tick();
      checks++; if (hgrant4 !== 4'(1 << m_g[0])) begin errors++; $display("FAIL rnd%0d_hgrant4 got %b want %b", k, hgrant4, 4'(1 << m_g[0])); end
      checks++; if (hmaster4 !== 4'(m_hm[0])) begin errors++; $display("FAIL rnd%0d_hmaster4 got %0d want %0d", k, hmaster4, m_hm[0]); end
      checks++; if (hmastlock4 !== m_lk[0]) begin errors++; $display("FAIL rnd%0d_hmastlock4 got %b want %b", k, hmastlock4, m_lk[0]); end
      checks++; if (hgrant2 !== 2'(1 << m_g[1])) begin errors++; $display("FAIL rnd%0d_hgrant2 got %b want %b", k, hgrant2, 2'(1 << m_g[1])); end
      checks++; if (hmaster2 !== 4'(m_hm[1])) begin errors++; $display("FAIL rnd%0d_hmaster2 got %0d want %0d", k, hmaster2, m_hm[1]); end
      checks++; if (hmastlock2 !== m_lk[1]) begin errors++; $display("FAIL rnd%0d_hmastlock2 got %b want %b", k, hmastlock2, m_lk[1]); end
    end
    hreset = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_g[u] = 0; m_hm[u] = 0; m_lk[u] = 1'b0; m_mask[u] = '0; m_done[u] = 0; m_len[u] = 0;
    end
    idle_inputs();
    hreset = 1'b1;
    @(negedge hclk);
    test_reset();
    test_round_robin();
    test_incr4();
    test_locked();
    test_split();
    test_reset_mid_split();
    test_all_masked();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
